// File: rtl/aes256_key_share_loader.sv
// Key share loader: collects eight 32-bit key words into SHARES Boolean shares.
// Define KEY_LOADER_ZEROIZE_EN to wipe the shares once the key has been issued.
module aes256_key_share_loader #(
  parameter int SHARES = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [31:0]               key_i,
  input  logic                      key_valid_i,
  output logic                      key_ready_o,
  input  logic [32*(SHARES-1)-1:0]  rand_i,
  input  logic                      clear_i,
  input  logic                      exp_valid_i,
  output logic [255:0]              k_o [0:SHARES-1],
  output logic                      kvalid_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    COLLECT,
    WAIT_EXP,
    ISSUE
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q;
  logic         first_key_q;
  logic [255:0] share_q [0:SHARES-1];
  logic         accept;
  logic         zeroize;
  logic [31:0]  mask_x;
  logic [7:0]   base;

  assign key_ready_o = (state_q == COLLECT);
  assign kvalid_o    = (state_q == ISSUE);
  assign busy_o      = (state_q != COLLECT);
  assign accept      = key_valid_i && key_ready_o && !clear_i;

  // Word slot cnt occupies bits [255-32*cnt -: 32]
  assign base = {~cnt_q, 5'h1f};

`ifdef KEY_LOADER_ZEROIZE_EN
  assign zeroize = (state_q == ISSUE);
`else
  assign zeroize = 1'b0;
`endif

  always_comb begin
    mask_x = '0;
    for (int s = 1; s < SHARES; s++) begin
      mask_x = mask_x ^ rand_i[32*s-1 -: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (accept && cnt_q == 3'd7) begin
          state_d = WAIT_EXP;
        end
      end
      WAIT_EXP: begin
        if (exp_valid_i || first_key_q) begin
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
    if (clear_i) begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      first_key_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (!clear_i && state_q == ISSUE) begin
        first_key_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SHARES; s++) begin
        share_q[s] <= '0;
      end
    end else if (clear_i || zeroize) begin
      for (int s = 0; s < SHARES; s++) begin
        share_q[s] <= '0;
      end
    end else if (accept) begin
      share_q[0][base -: 32] <= key_i ^ mask_x;
      for (int s = 1; s < SHARES; s++) begin
        share_q[s][base -: 32] <= rand_i[32*s-1 -: 32];
      end
    end
  end

  for (genvar g = 0; g < SHARES; g++) begin : g_out
    assign k_o[g] = share_q[g];
  end

endmodule

// File: tb/tb_aes256_key_share_loader.sv
// Bench for aes256_key_share_loader: vector table, directed corners,
// and randomized traffic against a word-count/issue reference model.
module tb_aes256_key_share_loader;

  localparam int SH = 3;
  localparam int RW = 32 * (SH - 1);

  logic           clk = 1'b0;
  logic           resetn;
  logic [31:0]    key_i;
  logic           key_valid_i;
  logic           key_ready_o;
  logic [RW-1:0]  rand_i;
  logic           clear_i;
  logic           exp_valid_i;
  logic [255:0]   k_o [0:SH-1];
  logic           kvalid_o;
  logic           busy_o;

  aes256_key_share_loader #(.SHARES(SH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .rand_i      (rand_i),
    .clear_i     (clear_i),
    .exp_valid_i (exp_valid_i),
    .k_o         (k_o),
    .kvalid_o    (kvalid_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: words collected so far, issue pending, shares
  int           m_got;
  bit           m_iss;
  bit           m_fk;
  logic [255:0] m_k [0:SH-1];
  logic [31:0]  rec [0:7];

  localparam logic [255:0] FIPS =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] ZKEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_got = 0;
    m_iss = 0;
    m_fk  = 1;
    for (int s = 0; s < SH; s++) m_k[s] = '0;
  endtask

  task automatic model(input bit kv, input logic [31:0] w,
                       input logic [RW-1:0] r, input bit clr, input bit ev);
    logic [31:0] x;
    int hi;
    if (clr) begin
      m_got = 0;
      m_iss = 0;
      for (int s = 0; s < SH; s++) m_k[s] = '0;
    end else if (m_iss) begin
      m_iss = 0;
      m_fk  = 0;
`ifdef KEY_LOADER_ZEROIZE_EN
      for (int s = 0; s < SH; s++) m_k[s] = '0;
`endif
    end else if (m_got == 8) begin
      if (ev || m_fk) begin
        m_iss = 1;
        m_got = 0;
      end
    end else if (kv) begin
      hi = 255 - 32 * m_got;
      x  = w;
      for (int s = 1; s < SH; s++) begin
        x = x ^ r[32*s-1 -: 32];
        m_k[s][hi -: 32] = r[32*s-1 -: 32];
      end
      m_k[0][hi -: 32] = x;
      m_got++;
    end
  endtask

  task automatic check_all();
    bit rdy;
    rdy = (m_got < 8) && !m_iss;
    chk("ready", 256'(key_ready_o), 256'(rdy));
    chk("busy", 256'(busy_o), 256'(!rdy));
    chk("kvalid", 256'(kvalid_o), 256'(m_iss));
    for (int s = 0; s < SH; s++)
      chk($sformatf("k_o[%0d]", s), k_o[s], m_k[s]);
  endtask

  // Called at a falling edge: check current outputs, drive next inputs
  task automatic step(input bit kv, input logic [31:0] w,
                      input logic [RW-1:0] r, input bit clr, input bit ev);
    check_all();
    key_valid_i = kv;
    key_i       = w;
    rand_i      = r;
    clear_i     = clr;
    exp_valid_i = ev;
    model(kv, w, r, clr, ev);
    @(negedge clk);
  endtask

  function automatic logic [RW-1:0] rnd();
    logic [RW-1:0] r;
    for (int s = 0; s < SH - 1; s++) r[32*s +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_key(input logic [255:0] key, input bit ev);
    logic [RW-1:0] r;
    for (int j = 0; j < 8; j++) begin
      r = rnd();
      rec[j] = r[31:0];
      step(1'b1, key[255-32*j -: 32], r, 1'b0, ev);
    end
  endtask

  function automatic logic [255:0] kxor();
    logic [255:0] x;
    x = '0;
    for (int s = 0; s < SH; s++) x = x ^ k_o[s];
    return x;
  endfunction

  // Waits for kvalid (bounded); checks latency and recombined key
  task automatic wait_issue(input string tag, input logic [255:0] key,
                            input bit chk_masks);
    int  t;
    bit  seen;
    seen = 0;
    t = 0;
    while (t < 8 && !seen) begin
      if (kvalid_o) begin
        seen = 1;
        chk({tag, "_latency"}, 256'(t), 256'(1));
        chk({tag, "_key"}, kxor(), key);
        if (chk_masks)
          for (int j = 0; j < 8; j++)
            chk($sformatf("%s_mask%0d", tag, j),
                256'(k_o[1][255-32*j -: 32]), 256'(rec[j]));
      end else begin
        step(1'b0, '0, '0, 1'b0, exp_valid_i);
        t++;
      end
    end
    if (!seen) chk({tag, "_kvalid_timeout"}, 256'(0), 256'(1));
  endtask

  typedef struct {
    bit          kv;
    logic [31:0] w;
    bit          rdy;
    bit          kvl;
    bit          bsy;
  } vec_t;

  vec_t tbl [0:10];

  initial begin
    logic [255:0] k2;
    logic [RW-1:0] r;

    for (int j = 0; j < 8; j++)
      tbl[j] = '{1'b1, {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)},
                 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0};

    resetn = 1'b0;
    key_i = '0;
    key_valid_i = 1'b0;
    rand_i = '0;
    clear_i = 1'b0;
    exp_valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_ready", 256'(key_ready_o), 256'(1));
    chk("rst_kvalid", 256'(kvalid_o), 256'(0));
    chk("rst_busy", 256'(busy_o), 256'(0));
    for (int s = 0; s < SH; s++) chk("rst_k", k_o[s], '0);
    resetn = 1'b1;
    @(negedge clk);

    // Zero masks, first key issues without exp_valid
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl%0d_ready", i), 256'(key_ready_o), 256'(tbl[i].rdy));
      chk($sformatf("tbl%0d_kvalid", i), 256'(kvalid_o), 256'(tbl[i].kvl));
      chk($sformatf("tbl%0d_busy", i), 256'(busy_o), 256'(tbl[i].bsy));
      if (i == 9) begin
        chk("zero_k0", k_o[0], ZKEY);
        chk("zero_k1", k_o[1], '0);
        chk("zero_k2", k_o[2], '0);
      end
      step(tbl[i].kv, tbl[i].w, '0, 1'b0, 1'b0);
    end

    // FIPS key, random masks
    send_key(FIPS, 1'b1);
    wait_issue("fips", FIPS, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef KEY_LOADER_ZEROIZE_EN
    for (int s = 0; s < SH; s++) chk("zeroize_k", k_o[s], '0);
`else
    chk("retain_key", kxor(), FIPS);
`endif
    chk("n3_ready", 256'(key_ready_o), 256'(1));

    // Backpressure
    k2 = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom};
    send_key(k2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("bp_kvalid_low", 256'(kvalid_o), 256'(0));
      chk("bp_ready_low", 256'(key_ready_o), 256'(0));
      chk("bp_hold", kxor(), k2);
      step(1'b1, $urandom, rnd(), 1'b0, 1'b0);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("bp_kvalid_pulse", 256'(kvalid_o), 256'(1));
    chk("bp_key", kxor(), k2);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_pulse_end", 256'(kvalid_o), 256'(0));

    // Abort after five words, with a word offered alongside clear
    for (int j = 0; j < 5; j++) step(1'b1, $urandom, rnd(), 1'b0, 1'b0);
    step(1'b1, 32'hdeadbeef, rnd(), 1'b1, 1'b0);
    for (int s = 0; s < SH; s++) chk("abort_k", k_o[s], '0);
    chk("abort_ready", 256'(key_ready_o), 256'(1));
    send_key(FIPS, 1'b1);
    wait_issue("abort", FIPS, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Async reset while waiting for the expander
    send_key(k2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_busy", 256'(busy_o), 256'(1));
    #2 resetn = 1'b0;
    #1;
    chk("arst_ready", 256'(key_ready_o), 256'(1));
    chk("arst_kvalid", 256'(kvalid_o), 256'(0));
    chk("arst_busy", 256'(busy_o), 256'(0));
    for (int s = 0; s < SH; s++) chk("arst_k", k_o[s], '0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("arst_no_kvalid", 256'(kvalid_o), 256'(0));
      step(1'b0, '0, '0, 1'b0, 1'b1);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = rnd();
      step($urandom_range(0, 99) < 75, $urandom, r,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30);
    end
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
